cnt_seq_checker: RTL and testbench

//  Receive-side checker for a free-running binary up-counter stream (e.g. a counter

---
 rtl/cnt_chk_pkg.sv | 16 +
 rtl/cnt_gray2bin.sv | 15 +
 rtl/cnt_seq_checker.sv | 120 ++++++++++++
 tb/tb_cnt_seq_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_chk_pkg.sv
// Shared types and helpers for the counter-sequence checker.
// Holds the checker state encoding and the saturating-increment helper.
package cnt_chk_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Caller narrows the result back to its own counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/cnt_gray2bin.sv
// Gray-code to binary converter, purely combinational.
// Zero latency; no flow control (follows its input every cycle).
// Binary bit i is the XOR of all Gray bits from the MSB down to i.
module cnt_gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
  end

endmodule

// File: rtl/cnt_seq_checker.sv
// Receive-side integrity checker for a free-running up-counter stream; flags and counts breaks.
// Outputs registered, one cycle after an accepted sample; no backpressure, a sample is taken whenever pi_valid=1.
// Define CNT_CHK_GRAY_EN when pi_cnt arrives Gray-coded; po_expect is always binary.
module cnt_seq_checker
  import cnt_chk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 3,
  parameter int LOSS_CNT  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pi_valid,
  input  logic [WIDTH-1:0]     pi_cnt,
  input  logic                 pi_err_clr,
  output logic                 po_locked,
  output logic                 po_err,
  output logic [ERR_CNT_W-1:0] po_err_cnt,
  output logic [WIDTH-1:0]     po_expect
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_e                 r_state;
  logic [WIDTH-1:0]       r_expect;
  logic [GW-1:0]          r_good_run;
  logic [BW-1:0]          r_bad_run;
  logic                   r_locked;
  logic                   r_err;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic [WIDTH-1:0]       w_bin;
  logic [WIDTH-1:0]       w_next;
  logic                   w_match;
  logic                   w_err_evt;

`ifdef CNT_CHK_GRAY_EN
  cnt_gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .i_gray (pi_cnt),
    .o_bin  (w_bin)
  );
`else
  assign w_bin = pi_cnt;
`endif

  // Modulo arithmetic makes the all-ones -> zero wrap a normal match.
  assign w_next    = w_bin + WIDTH'(1);
  assign w_match   = (w_bin == r_expect);
  assign w_err_evt = pi_valid && (r_state == ST_LOCKED) && !w_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_expect   <= '0;
      r_good_run <= '0;
      r_bad_run  <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err_evt;
      if (pi_valid) begin
        // Every sample re-anchors the expectation, match or not.
        r_expect <= w_next;
        case (r_state)
          ST_HUNT: begin
            r_good_run <= '0;
            r_state    <= ST_CONFIRM;
          end
          ST_CONFIRM: begin
            if (!w_match) begin
              r_good_run <= '0;
            end else if (r_good_run == GW'(LOCK_CNT - 1)) begin
              r_good_run <= '0;
              r_bad_run  <= '0;
              r_locked   <= 1'b1;
              r_state    <= ST_LOCKED;
            end else begin
              r_good_run <= r_good_run + GW'(1);
            end
          end
          ST_LOCKED: begin
            if (w_match) begin
              r_bad_run <= '0;
            end else if (r_bad_run == BW'(LOSS_CNT - 1)) begin
              r_bad_run <= '0;
              r_locked  <= 1'b0;
              r_state   <= ST_HUNT;
            end else begin
              r_bad_run <= r_bad_run + BW'(1);
            end
          end
          default: begin
            r_locked <= 1'b0;
            r_state  <= ST_HUNT;
          end
        endcase
      end
    end
  end

  // Clear wins over the old value but not over an error in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (pi_err_clr) begin
      r_err_cnt <= w_err_evt ? ERR_CNT_W'(1) : '0;
    end else if (w_err_evt) begin
      r_err_cnt <= ERR_CNT_W'(sat_inc(32'(r_err_cnt), 32'(ERR_MAX)));
    end
  end

  assign po_locked  = r_locked;
  assign po_err     = r_err;
  assign po_err_cnt = r_err_cnt;
  assign po_expect  = r_expect;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed plus randomized bench for cnt_seq_checker; a second instance with a 2-bit error counter covers saturation.
module tb_cnt_seq_checker;

  localparam int LOCK = 3;
  localparam int LOSS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pi_valid = 1'b0;
  logic [3:0] pi_cnt = '0;
  logic       pi_err_clr = 1'b0;

  logic       po_locked, po_err, po_locked2, po_err2;
  logic [7:0] po_err_cnt;
  logic [1:0] po_err_cnt2;
  logic [3:0] po_expect, po_expect2;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_anchored, m_locked, m_err;
  int m_good, m_bad, m_exp, m_c8, m_c2;

  always #5 clk = ~clk;

  cnt_seq_checker #(.WIDTH(4), .LOCK_CNT(3), .LOSS_CNT(2), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .pi_valid(pi_valid), .pi_cnt(pi_cnt), .pi_err_clr(pi_err_clr),
    .po_locked(po_locked), .po_err(po_err), .po_err_cnt(po_err_cnt), .po_expect(po_expect)
  );

  cnt_seq_checker #(.WIDTH(4), .LOCK_CNT(3), .LOSS_CNT(2), .ERR_CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .pi_valid(pi_valid), .pi_cnt(pi_cnt), .pi_err_clr(pi_err_clr),
    .po_locked(po_locked2), .po_err(po_err2), .po_err_cnt(po_err_cnt2), .po_expect(po_expect2)
  );

  function automatic logic [3:0] enc(input logic [3:0] b);
`ifdef CNT_CHK_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_anchored = 0; m_locked = 0; m_err = 0;
    m_good = 0; m_bad = 0; m_exp = 0; m_c8 = 0; m_c2 = 0;
  endtask

  task automatic model_step(input bit val, input int v, input bit clr);
    m_err = 0;
    if (val) begin
      if (!m_anchored) begin
        m_anchored = 1;
        m_good = 0;
      end else if (!m_locked) begin
        if (v == m_exp) begin
          m_good++;
          if (m_good == LOCK) begin m_locked = 1; m_good = 0; m_bad = 0; end
        end else begin
          m_good = 0;
        end
      end else if (v == m_exp) begin
        m_bad = 0;
      end else begin
        m_err = 1;
        m_bad++;
        if (m_bad == LOSS) begin m_locked = 0; m_anchored = 0; m_bad = 0; end
      end
      m_exp = (v + 1) % 16;
    end
    if (clr) begin m_c8 = 0; m_c2 = 0; end
    if (m_err) begin
      m_c8 = (m_c8 + 1 > 255) ? 255 : m_c8 + 1;
      m_c2 = (m_c2 + 1 > 3) ? 3 : m_c2 + 1;
    end
  endtask

  task automatic compare_all();
    check("locked", 32'(po_locked), 32'(m_locked));
    check("err", 32'(po_err), 32'(m_err));
    check("err_cnt", 32'(po_err_cnt), 32'(m_c8));
    check("expect", 32'(po_expect), 32'(m_exp));
    check("locked_w2", 32'(po_locked2), 32'(m_locked));
    check("err_cnt_w2", 32'(po_err_cnt2), 32'(m_c2));
    check("expect_w2", 32'(po_expect2), 32'(m_exp));
  endtask

  // One clock: drive on the falling edge, check 1 time unit after the rising edge.
  task automatic cyc(input bit val, input int v, input bit clr);
    @(negedge clk);
    rst        = 1'b0;
    pi_valid   = val;
    pi_cnt     = enc(4'(v % 16));
    pi_err_clr = clr;
    model_step(val, v % 16, clr);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pi_valid = 1'b0; pi_err_clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int e;
    model_reset();

    // 1: straight run with wrap
    do_reset();
    check("rst_locked", 32'(po_locked), 32'd0);
    check("rst_err_cnt", 32'(po_err_cnt), 32'd0);
    for (int v = 0; v < 18; v++) begin
      cyc(1, v % 16, 0);
      if (v == 2) check("s1_unlocked_after2", 32'(po_locked), 32'd0);
      if (v == 3) check("s1_locked_after3", 32'(po_locked), 32'd1);
      if (v == 16) check("s1_no_err_wrap", 32'(po_err), 32'd0);
    end
    check("s1_expect_end", 32'(po_expect), 32'd2);
    check("s1_err_cnt", 32'(po_err_cnt), 32'd0);

    // 2: single jump while locked
    for (int v = 2; v <= 6; v++) cyc(1, v, 0);
    cyc(1, 9, 0);
    check("s2_err_pulse", 32'(po_err), 32'd1);
    cyc(1, 10, 0);
    check("s2_err_single", 32'(po_err), 32'd0);
    cyc(1, 11, 0);
    check("s2_err_cnt", 32'(po_err_cnt), 32'd1);
    check("s2_still_locked", 32'(po_locked), 32'd1);

    // 3: two consecutive breaks drop lock, then relock
    do_reset();
    for (int v = 0; v <= 6; v++) cyc(1, v, 0);
    cyc(1, 9, 0);
    cyc(1, 3, 0);
    check("s3_err_second", 32'(po_err), 32'd1);
    check("s3_err_cnt", 32'(po_err_cnt), 32'd2);
    check("s3_unlocked", 32'(po_locked), 32'd0);
    for (int v = 4; v <= 7; v++) begin
      cyc(1, v, 0);
      if (v == 6) check("s3_not_yet", 32'(po_locked), 32'd0);
    end
    check("s3_relock", 32'(po_locked), 32'd1);

    // 4: gaps are transparent
    do_reset();
    for (int v = 0; v <= 8; v++) begin
      cyc(1, v, 0);
      if (v == 2) check("s4_unlocked_after2", 32'(po_locked), 32'd0);
      if (v == 3) check("s4_locked_after3", 32'(po_locked), 32'd1);
      cyc(0, int'($urandom_range(0, 15)), 0);
    end
    check("s4_err_cnt", 32'(po_err_cnt), 32'd0);
    check("s4_expect", 32'(po_expect), 32'd9);

    // 5: saturation of the narrow counter, then clear coincident with an error
    do_reset();
    for (int v = 0; v <= 3; v++) cyc(1, v, 0);
    e = 4;
    for (int k = 0; k < 5; k++) begin
      cyc(1, e + 7, 0);
      e = (e + 8) % 16;
      cyc(1, e, 0);
      e = (e + 1) % 16;
    end
    check("s5_sat_w2", 32'(po_err_cnt2), 32'd3);
    check("s5_cnt_w8", 32'(po_err_cnt), 32'd5);
    check("s5_locked", 32'(po_locked), 32'd1);
    cyc(1, e + 7, 1);
    check("s5_clr_err_w2", 32'(po_err_cnt2), 32'd1);
    check("s5_clr_err_w8", 32'(po_err_cnt), 32'd1);
    e = (e + 8) % 16;
    cyc(1, e, 1);
    check("s5_clr_only", 32'(po_err_cnt), 32'd0);

    // 6: reset while locked with errors recorded
    do_reset();
    for (int v = 0; v <= 3; v++) cyc(1, v, 0);
    e = 4;
    for (int k = 0; k < 4; k++) begin
      cyc(1, e + 5, 0);
      e = (e + 6) % 16;
      cyc(1, e, 0);
      e = (e + 1) % 16;
    end
    check("s6_cnt4", 32'(po_err_cnt), 32'd4);
    check("s6_locked", 32'(po_locked), 32'd1);
    do_reset();
    check("s6_rst_locked", 32'(po_locked), 32'd0);
    check("s6_rst_cnt", 32'(po_err_cnt), 32'd0);
    check("s6_rst_expect", 32'(po_expect), 32'd0);

    // Randomized traffic: mostly in-sequence with occasional jumps, gaps and clears
    for (int n = 0; n < 600; n++) begin
      bit val, clr;
      int v;
      val = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      if (!val || $urandom_range(0, 7) == 0) v = int'($urandom_range(0, 15));
      else v = m_exp;
      cyc(val, v, clr);
      if (n == 300) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
